test_harness_serializer: RTL and testbench



---
 rtl/test_harness_serializer.sv | 167 ++++++++++++++++
 tb/tb_test_harness_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/test_harness_serializer.sv
// Logic-analyzer tap: captures TEST_DATA whenever it changes, queues it, and streams it out LSB chunk first.
// Optional macro SERIALIZER_CHECKSUM_EN appends an XOR checksum chunk to every frame.
module test_harness_serializer #(
   parameter int DATA_W      = 48,
   parameter int CHUNK_W     = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 1,
   parameter int GAP_CYCLES  = 2
) (
   input  logic               CLK_1MHZ,
   input  logic               RESET,
   input  logic [DATA_W-1:0]  TEST_DATA,
   input  logic               CAPTURE_EN,
   output logic [CHUNK_W-1:0] D,
   output logic               D_OE,
   output logic               FRAME,
   output logic               STROBE,
   output logic               BUSY,
   output logic               OVERFLOW
);
   localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
   localparam int PAD_W  = NCHUNK * CHUNK_W;
`ifdef SERIALIZER_CHECKSUM_EN
   localparam int NTOT   = NCHUNK + 1;
`else
   localparam int NTOT   = NCHUNK;
`endif
   localparam int FRM_W  = NTOT * CHUNK_W;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int HW     = $clog2(HOLD_CYCLES + 1);
   localparam int GW     = $clog2(GAP_CYCLES + 2);
   localparam int IW     = $clog2(NTOT + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   // Whole frame laid out chunk 0 at the bottom, so sending is a plain right shift.
   function automatic logic [FRM_W-1:0] frame_of(input logic [DATA_W-1:0] w);
      logic [PAD_W-1:0] p;
`ifdef SERIALIZER_CHECKSUM_EN
      logic [CHUNK_W-1:0] c;
`endif
      p = PAD_W'(w);
`ifdef SERIALIZER_CHECKSUM_EN
      c = '0;
      for (int k = 0; k < NCHUNK; k++) c = c ^ p[k*CHUNK_W +: CHUNK_W];
      return {c, p};
`else
      return p;
`endif
   endfunction

   state_t             state, state_nxt;
   logic [HW-1:0]      hold_cnt, hold_nxt;
   logic [GW-1:0]      gap_cnt, gap_nxt;
   logic [IW-1:0]      idx, idx_nxt;
   logic [FRM_W-1:0]   shreg, shreg_nxt, shifted;
   logic [CHUNK_W-1:0] d_nxt;
   logic               oe_nxt, frame_nxt, strobe_nxt, busy_nxt;
   logic [DATA_W-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count, count_nxt;
   logic [DATA_W-1:0]  last_word;
   logic               last_vld, capture, fifo_full, pop, push;

   always_comb begin
      capture   = CAPTURE_EN && (!last_vld || (TEST_DATA != last_word));
      fifo_full = (count == (AW+1)'(FIFO_DEPTH));
      pop       = (state == S_IDLE) && (count != '0);
      push      = capture && (!fifo_full || pop);
      count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   always_comb begin
      state_nxt  = state;
      hold_nxt   = hold_cnt;
      gap_nxt    = gap_cnt;
      idx_nxt    = idx;
      shreg_nxt  = shreg;
      shifted    = shreg >> CHUNK_W;
      d_nxt      = '0;
      oe_nxt     = 1'b0;
      frame_nxt  = 1'b0;
      strobe_nxt = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (pop) begin
               shreg_nxt  = frame_of(mem[rd_ptr]);
               d_nxt      = shreg_nxt[CHUNK_W-1:0];
               oe_nxt     = 1'b1;
               frame_nxt  = 1'b1;
               strobe_nxt = 1'b1;
               hold_nxt   = '0;
               idx_nxt    = '0;
               state_nxt  = S_SEND;
            end
         end
         S_SEND: begin
            if (int'(hold_cnt) + 1 < HOLD_CYCLES) begin
               hold_nxt = hold_cnt + 1'b1;
               d_nxt    = D;
               oe_nxt   = 1'b1;
            end else if (int'(idx) + 1 < NTOT) begin
               hold_nxt   = '0;
               idx_nxt    = idx + 1'b1;
               shreg_nxt  = shifted;
               d_nxt      = shifted[CHUNK_W-1:0];
               oe_nxt     = 1'b1;
               strobe_nxt = 1'b1;
            end else if (GAP_CYCLES > 0) begin
               gap_nxt   = '0;
               state_nxt = S_GAP;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            if (int'(gap_cnt) + 1 >= GAP_CYCLES) state_nxt = S_IDLE;
            else gap_nxt = gap_cnt + 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
      busy_nxt = (count_nxt != '0) || (state_nxt != S_IDLE);
   end

   // Control and output registers
   always_ff @(posedge CLK_1MHZ) begin
      if (RESET) begin
         state    <= S_IDLE;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         idx      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last_vld <= 1'b0;
         D        <= '0;
         D_OE     <= 1'b0;
         FRAME    <= 1'b0;
         STROBE   <= 1'b0;
         BUSY     <= 1'b0;
         OVERFLOW <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         gap_cnt  <= gap_nxt;
         idx      <= idx_nxt;
         count    <= count_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (capture) last_vld <= 1'b1;
         if (capture && !push) OVERFLOW <= 1'b1;
         D        <= d_nxt;
         D_OE     <= oe_nxt;
         FRAME    <= frame_nxt;
         STROBE   <= strobe_nxt;
         BUSY     <= busy_nxt;
      end
   end

   // Data storage
   always_ff @(posedge CLK_1MHZ) begin
      if (capture) last_word <= TEST_DATA;
      if (push) mem[wr_ptr] <= TEST_DATA;
      shreg <= shreg_nxt;
   end

endmodule

// File: tb/tb_test_harness_serializer.sv
// Bench for test_harness_serializer: a default instance and a narrow, slow, shallow-FIFO instance,
// exercised by vector tables, a hand-built overflow sequence and randomized traffic.
module tb_test_harness_serializer;
   localparam int A_DEPTH = 4, A_HOLD = 1, A_GAP = 2, A_NCH = 6;
   localparam int B_HOLD = 3, B_GAP = 0, B_NCH = 3;
`ifdef SERIALIZER_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int A_NTOT = A_NCH + EXTRA;
   localparam int B_NTOT = B_NCH + EXTRA;
   localparam int B_P    = B_NTOT * B_HOLD + B_GAP + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst = 1'b1, a_en = 1'b0;
   logic [47:0] a_data = '0;
   logic [7:0]  a_d;
   logic        a_oe, a_fr, a_st, a_busy, a_ovf;
   logic        b_rst = 1'b1, b_en = 1'b0;
   logic [19:0] b_data = '0;
   logic [7:0]  b_d;
   logic        b_oe, b_fr, b_st, b_busy, b_ovf;

   test_harness_serializer u_a (
      .CLK_1MHZ(clk), .RESET(a_rst), .TEST_DATA(a_data), .CAPTURE_EN(a_en),
      .D(a_d), .D_OE(a_oe), .FRAME(a_fr), .STROBE(a_st), .BUSY(a_busy), .OVERFLOW(a_ovf));

   test_harness_serializer #(.DATA_W(20), .CHUNK_W(8), .FIFO_DEPTH(2), .HOLD_CYCLES(B_HOLD),
                             .GAP_CYCLES(B_GAP)) u_b (
      .CLK_1MHZ(clk), .RESET(b_rst), .TEST_DATA(b_data), .CAPTURE_EN(b_en),
      .D(b_d), .D_OE(b_oe), .FRAME(b_fr), .STROBE(b_st), .BUSY(b_busy), .OVERFLOW(b_ovf));

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Chunk k of a zero-padded word; index nch is the XOR checksum of the nch data chunks.
   function automatic logic [7:0] chunk_of(input logic [63:0] w, input int nch, input int k);
      logic [7:0] x;
      x = '0;
      if (k < nch) return w[8*k +: 8];
      for (int j = 0; j < nch; j++) x = x ^ w[8*j +: 8];
      return x;
   endfunction

   // Transaction-level model of instance a: a word queue plus the edge at which the serializer is free.
   logic [47:0] mq[$];
   logic [47:0] m_last, m_cur;
   bit          m_lv, m_ovf, m_act, m_on;
   longint      m_cyc = 0, m_start = 0, m_free = 0;

   always @(posedge clk) begin
      m_cyc++;
      if (a_rst) begin
         mq.delete();
         m_lv = 0; m_ovf = 0; m_act = 0; m_free = 0; m_on = 1;
      end else begin
         if (m_cyc >= m_free && mq.size() > 0) begin
            m_cur   = mq.pop_front();
            m_start = m_cyc;
            m_act   = 1;
            m_free  = m_cyc + A_NTOT * A_HOLD + A_GAP + 1;
         end
         if (a_en && (!m_lv || a_data != m_last)) begin
            m_last = a_data;
            m_lv   = 1;
            if (mq.size() < A_DEPTH) mq.push_back(a_data);
            else m_ovf = 1;
         end
      end
   end

   always @(negedge clk) begin : model_chk
      longint     off;
      bit         in_f, busy_e;
      logic [7:0] d_e;
      if (m_on) begin
         off    = m_cyc - m_start;
         in_f   = m_act && off < A_NTOT * A_HOLD;
         d_e    = in_f ? chunk_of(64'(m_cur), A_NCH, int'(off / A_HOLD)) : 8'h00;
         busy_e = (mq.size() > 0) || (m_act && off < A_NTOT * A_HOLD + A_GAP);
         check("model_a", {51'b0, a_d, a_oe, a_fr, a_st, a_busy, a_ovf},
               {51'b0, d_e, in_f, in_f && off == 0, in_f && (off % A_HOLD) == 0, busy_e, m_ovf});
      end
   end

   typedef struct {
      bit          rst;
      bit          en;
      logic [47:0] data;
      logic [12:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input bit rst, input bit en, input logic [47:0] data,
                               input logic [7:0] d, input bit oe, input bit fr, input bit st,
                               input bit busy, input bit ovf);
      vec_t v;
      v.rst = rst; v.en = en; v.data = data;
      v.exp = {d, oe, fr, st, busy, ovf};
      return v;
   endfunction

   localparam logic [47:0] W1 = 48'h060504030201;
   localparam logic [47:0] W2 = 48'h0c0b0a090807;
   localparam logic [47:0] W3 = 48'h1211100f0e0d;
   localparam logic [47:0] W4 = 48'hdeadbeef0042;

   logic [19:0] bw[5];
   logic [47:0] pool[8];
   logic [7:0]  bd_e;
   int          s, f, off, burst;
   bit          in_b;

   initial begin
      // Table: basic frame, mid-frame reset with a queued word, and capture disabled.
      tbl.push_back(mk(1, 1, W1, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, W1, 8'h00, 0, 0, 0, 1, 0));
      for (int k = 1; k <= 6; k++) tbl.push_back(mk(0, 1, W1, 8'(k), 1, k == 1, 1, 1, 0));
`ifdef SERIALIZER_CHECKSUM_EN
      tbl.push_back(mk(0, 1, W1, 8'h07, 1, 0, 1, 1, 0));
`endif
      tbl.push_back(mk(0, 1, W1, 8'h00, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, W1, 8'h00, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, W1, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, W1, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, W2, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, W2, 8'h00, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, W3, 8'h07, 1, 1, 1, 1, 0));
      tbl.push_back(mk(0, 1, W3, 8'h08, 1, 0, 1, 1, 0));
      tbl.push_back(mk(0, 1, W3, 8'h09, 1, 0, 1, 1, 0));
      tbl.push_back(mk(1, 1, W3, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, W3, 8'h00, 0, 0, 0, 1, 0));
      for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 1, W3, 8'h0d + 8'(k), 1, k == 0, 1, 1, 0));
`ifdef SERIALIZER_CHECKSUM_EN
      tbl.push_back(mk(0, 1, W3, 8'h1f, 1, 0, 1, 1, 0));
`endif
      tbl.push_back(mk(0, 1, W3, 8'h00, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, W3, 8'h00, 0, 0, 0, 1, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, W3, 8'h00, 0, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, W4, 8'h00, 0, 0, 0, 0, 0));

      @(negedge clk);
      foreach (tbl[i]) begin
         a_rst = tbl[i].rst; a_en = tbl[i].en; a_data = tbl[i].data;
         @(negedge clk);
         check($sformatf("vec%0d", i), {51'b0, a_d, a_oe, a_fr, a_st, a_busy, a_ovf},
               {51'b0, tbl[i].exp});
      end

      // Shallow FIFO: five distinct words on consecutive edges, only the first three survive.
      bw[0] = 20'hABCDE; bw[1] = 20'h12345; bw[2] = 20'h0F0F0; bw[3] = 20'h55AA5; bw[4] = 20'h00001;
      b_rst = 1; b_en = 1;
      @(negedge clk);
      check("b_reset", {58'b0, b_d, b_oe, b_fr, b_st, b_busy, b_ovf}, 64'h0);
      b_rst = 0;
      for (int e = 1; e <= 48; e++) begin
         if (e <= 5) b_data = bw[e-1];
         @(negedge clk);
         s    = e - 2;
         f    = (s >= 0) ? s / B_P : 0;
         off  = (s >= 0) ? s % B_P : 0;
         in_b = (s >= 0) && (f < 3) && (off < B_NTOT * B_HOLD);
         bd_e = in_b ? chunk_of(64'(bw[f]), B_NCH, off / B_HOLD) : 8'h00;
         check($sformatf("b_edge%0d", e), {58'b0, b_d, b_oe, b_fr, b_st, b_busy, b_ovf},
               {58'b0, bd_e, in_b, in_b && off == 0, in_b && (off % B_HOLD) == 0,
                s < 2 * B_P + B_NTOT * B_HOLD + B_GAP, e >= 4});
      end
      b_rst = 1;
      @(negedge clk);
      check("b_ovf_clear", {58'b0, b_d, b_oe, b_fr, b_st, b_busy, b_ovf}, 64'h0);
      b_rst = 0;

      // Randomized traffic on instance a, judged every cycle by the model.
      for (int i = 0; i < 8; i++) pool[i] = 48'({$urandom, $urandom});
      pool[7] = '0;
      burst = 0;
      for (int c = 0; c < 4000; c++) begin
         a_rst = ($urandom_range(0, 999) < 4);
         a_en  = ($urandom_range(0, 9) != 0);
         if (burst > 0) begin
            a_data = pool[$urandom_range(0, 7)];
            burst--;
         end else if ($urandom_range(0, 19) == 0) begin
            a_data = pool[$urandom_range(0, 7)];
         end
         if ($urandom_range(0, 199) == 0) burst = 6;
         @(negedge clk);
      end
      a_rst = 0; a_en = 0;
      repeat (30) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
